adc_scan_scheduler: RTL and testbench
=====================================

Name: adc_scan_scheduler

Overview:
- Sequences the shared 12-bit SPI ADC interface.
- Runs periodic scans over a configurable channel mask and serves one-shot conversion requests from a second requester with priority between scan conversions.
- Keeps a per-channel result bank with freshness flags.
- Sits between the temperature control logic and the ADC SPI interface, driving its start/channel inputs and consuming its adc_data/adc_valid.

Parameters:
- TIMEOUT_CYCLES, 1024: clk cycles to wait for adc_valid after start before declaring timeout.
- TMO_W, 11: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  synchronous, active-high reset
- scan_en  in  1  enables periodic scanning
- chan_mask  in  8  channels included in a scan (bit n = channel n)
- period_tick  in  1  one-cycle pulse requesting a new scan
- req_valid  in  1  one-shot conversion request
- req_chan  in  3  requested channel
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse: request response
- rsp_data  out  12  request result
- rsp_err  out  1  request timed out (qualifies rsp_valid)
- adc_start  out  1  one-cycle start pulse to ADC interface
- adc_channel  out  3  channel to ADC interface, held from start until completion
- adc_data  in  12  ADC result
- adc_valid  in  1  ADC result strobe
- rd_chan  in  3  result bank read address
- rd_data  out  12  result[rd_chan], combinational
- rd_fresh  out  1  fresh[rd_chan], combinational
- rd_ack  in  1  clears fresh[rd_chan]
- scan_done  out  1  one-cycle pulse at end of scan
- scan_overrun  out  1  one-cycle pulse: period_tick while a scan is pending/active
- timeout_err  out  1  one-cycle pulse on any timeout
- busy  out  1  FSM not in IDLE, or a scan pending

Behaviour:
- Reset (synchronous, rst=1):
  - FSM to IDLE.
  - All outputs 0; result bank 0; fresh flags 0.
  - scan_pending 0; scan pointer 0.
  - Reset mid-conversion abandons it; a later adc_valid is ignored.
- States and transitions:
  - IDLE:
    - req_ready=1.
    - If req_valid: latch req_chan, mark source=REQ, go ISSUE.
    - Else if scan_pending: find the lowest channel >= scan_ptr with latched_mask set, mark source=SCAN, go ISSUE.
    - Request always beats scan continuation.
  - ISSUE:
    - adc_start=1 for exactly one cycle; adc_channel=selected channel.
    - Clear the timeout counter; go WAIT.
  - WAIT:
    - adc_channel held.
    - On adc_valid: capture adc_data, go STORE.
    - Else if counter == TIMEOUT_CYCLES-1: pulse timeout_err, go IDLE with no result stored.
    - On timeout with source=REQ: rsp_valid=1, rsp_err=1, rsp_data=0.
    - On timeout with source=SCAN: the channel is skipped.
  - STORE:
    - Write result[ch]; set fresh[ch].
    - If source=REQ: rsp_valid=1, rsp_data=sample, rsp_err=0.
    - If source=SCAN: scan_ptr=ch+1. If no set mask bit remains above ch: scan_done=1, clear scan_pending, scan_ptr=0.
    - Go IDLE.
- Scan start:
  - period_tick with scan_en=1, scan_pending=0 and chan_mask!=0 sets scan_pending and latches chan_mask into latched_mask.
  - chan_mask changes mid-scan have no effect.
  - period_tick while scan_pending=1 causes a scan_overrun pulse; it is otherwise ignored.
  - period_tick with chan_mask==0 or scan_en=0 is ignored.
  - scan_en deassertion mid-scan lets the current scan finish.
- Latency:
  - Request accepted in IDLE.
  - adc_start on the next cycle.
  - rsp_valid on the cycle after the adc_valid capture cycle, i.e. 2 cycles after adc_valid.
- Late or spurious adc_valid outside WAIT is ignored.
- Freshness:
  - rd_ack clears fresh[rd_chan].
  - A simultaneous STORE to the same channel wins (fresh stays 1).
- busy = (state!=IDLE) | scan_pending.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- Enabled:
  - SCAN results are IIR-filtered per channel: result <= result + ((sample - result) >>> 2). Signed 13-bit difference, arithmetic shift, truncate to 12 bits.
  - The first sample after reset per channel (primed[ch]=0) loads directly and sets primed[ch].
  - REQ results always write the raw sample to rsp_data and to result[ch], and set primed[ch].
- Disabled: SCAN results are stored raw; the primed logic is absent.

Test Plan:
- Scan stimulus: chan_mask=8'b1000_0101, period_tick; ADC model returns 12'h100+ch after 200 cycles.
  - Response: adc_start for ch 0, 2, 7 in order.
  - result[0]=12'h100, result[2]=12'h102, result[7]=12'h107; fresh=1 for each.
  - One scan_done pulse after ch 7.
- Request during scan: req_valid, req_chan=5 asserted while ch 0 converts.
  - Response: ch 5 converted before ch 2.
  - rsp_valid with rsp_data=12'h105, rsp_err=0; scan then completes ch 2 and ch 7.
- Timeout: ADC model never asserts adc_valid; request ch 3.
  - Response: timeout_err and rsp_valid/rsp_err=1 exactly TIMEOUT_CYCLES cycles after the WAIT entry; fresh[3] stays 0.
- Overrun and fresh race:
  - Second period_tick mid-scan -> scan_overrun pulse; only one scan_done.
  - rd_ack on ch 2 in the same cycle as the ch 2 STORE -> fresh[2]=1.
- Reset mid-WAIT: rst=1 for 1 cycle, then adc_valid arrives.
  - Response: no store, all outputs 0, busy=0.
- ADC_SCAN_AVG_EN defined: scans of ch 1 return 12'h400, then 12'h800.
  - Response: result[1]=12'h400, then 12'h500.

Source files
------------

// File: rtl/adc_scan_scheduler_if.sv
// Request/response and ADC-side signal bundle of adc_scan_scheduler.
// master = the scheduler, slave = requester plus ADC SPI interface.
interface adc_scan_scheduler_if;
  logic        req_valid;
  logic [2:0]  req_chan;
  logic        req_ready;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic        rsp_err;
  logic        adc_start;
  logic [2:0]  adc_channel;
  logic [11:0] adc_data;
  logic        adc_valid;

  modport master (
    input  req_valid, req_chan, adc_data, adc_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_channel
  );

  modport slave (
    output req_valid, req_chan, adc_data, adc_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_channel
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Shared ADC sequencer: periodic masked scans, priority one-shot requests, result bank.
// Define ADC_SCAN_AVG_EN to IIR-filter scan results per channel.
module adc_scan_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMO_W          = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic [7:0]           chan_mask,
  input  logic                 period_tick,
  adc_scan_scheduler_if.master bus,
  input  logic [2:0]           rd_chan,
  output logic [11:0]          rd_data,
  output logic                 rd_fresh,
  input  logic                 rd_ack,
  output logic                 scan_done,
  output logic                 scan_overrun,
  output logic                 timeout_err,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;
  state_e state_q, state_d;

  logic [2:0]       ch_q, ch_d;
  logic             src_req_q, src_req_d;
  logic [11:0]      sample_q;
  logic [TMO_W-1:0] tmo_q;
  logic             scan_pending_q;
  logic [2:0]       scan_ptr_q;
  logic [7:0]       mask_q;
  logic [11:0]      result_q [8];
  logic [7:0]       fresh_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [11:0]      rsp_data_q;
  logic             scan_done_q, overrun_q, timeout_q;

  logic [2:0]  scan_next;
  logic        scan_found;
  logic        more_above;
  logic        tmo_hit;
  logic        tmo_fire;
  logic        scan_advance;
  logic [11:0] wr_value;

  always_comb begin
    scan_next  = '0;
    scan_found = 1'b0;
    // Descending loop so the lowest qualifying channel is the last assignment.
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) >= scan_ptr_q)) begin
        scan_next  = 3'(i);
        scan_found = 1'b1;
      end
    end
    more_above = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i] && (3'(i) > ch_q)) more_above = 1'b1;
    end
  end

  assign tmo_hit      = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_fire     = (state_q == StWait) && !bus.adc_valid && tmo_hit;
  // A scan channel finishes either by storing or by being skipped on timeout.
  assign scan_advance = !src_req_q && ((state_q == StStore) || tmo_fire);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    src_req_d = src_req_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          ch_d      = bus.req_chan;
          src_req_d = 1'b1;
          state_d   = StIssue;
        end else if (scan_pending_q && scan_found) begin
          ch_d      = scan_next;
          src_req_d = 1'b0;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.adc_valid) state_d = StStore;
        else if (tmo_hit)  state_d = StIdle;
      end
      StStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef ADC_SCAN_AVG_EN
  logic [7:0]         primed_q;
  logic signed [12:0] diff;
  logic signed [12:0] step;

  always_comb begin
    diff = $signed({1'b0, sample_q}) - $signed({1'b0, result_q[ch_q]});
    step = diff >>> 2;
    if (src_req_q || !primed_q[ch_q]) wr_value = sample_q;
    else                              wr_value = result_q[ch_q] + step[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst)                         primed_q        <= '0;
    else if (state_q == StStore)     primed_q[ch_q]  <= 1'b1;
  end
`else
  assign wr_value = sample_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      src_req_q      <= 1'b0;
      sample_q       <= '0;
      tmo_q          <= '0;
      scan_pending_q <= 1'b0;
      scan_ptr_q     <= '0;
      mask_q         <= '0;
      fresh_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
      scan_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      for (int i = 0; i < 8; i++) result_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      src_req_q   <= src_req_d;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;

      if (state_q == StIssue)     tmo_q <= '0;
      else if (state_q == StWait) tmo_q <= tmo_q + 1'b1;

      if ((state_q == StWait) && bus.adc_valid) sample_q <= bus.adc_data;

      if (tmo_fire) begin
        timeout_q <= 1'b1;
        if (src_req_q) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_data_q  <= '0;
        end
      end

      if (state_q == StStore) begin
        result_q[ch_q] <= wr_value;
        if (src_req_q) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sample_q;
        end
      end

      // Later assignment lets a same-cycle store keep the flag set.
      if (rd_ack)             fresh_q[rd_chan] <= 1'b0;
      if (state_q == StStore) fresh_q[ch_q]    <= 1'b1;

      if (scan_advance) begin
        if (more_above) begin
          scan_ptr_q <= ch_q + 3'd1;
        end else begin
          scan_ptr_q     <= '0;
          scan_pending_q <= 1'b0;
          scan_done_q    <= 1'b1;
        end
      end

      if (period_tick) begin
        if (scan_pending_q) begin
          overrun_q <= 1'b1;
        end else if (scan_en && (chan_mask != 8'd0)) begin
          scan_pending_q <= 1'b1;
          mask_q         <= chan_mask;
        end
      end
    end
  end

  assign bus.req_ready   = (state_q == StIdle) && !rst;
  assign bus.adc_start   = (state_q == StIssue);
  assign bus.adc_channel = ch_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign rd_data         = result_q[rd_chan];
  assign rd_fresh        = fresh_q[rd_chan];
  assign scan_done       = scan_done_q;
  assign scan_overrun    = overrun_q;
  assign timeout_err     = timeout_q;
  assign busy            = (state_q != StIdle) | scan_pending_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: expected start channels and responses are queued when
// stimulus is driven and popped by a monitor as the DUT produces them.
module tb_adc_scan_scheduler;
  localparam int unsigned Tmo    = 1024;
  localparam int unsigned AdcLat = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [7:0]  chan_mask;
  logic        period_tick;
  logic [2:0]  rd_chan;
  logic [11:0] rd_data;
  logic        rd_fresh;
  logic        rd_ack;
  logic        scan_done;
  logic        scan_overrun;
  logic        timeout_err;
  logic        busy;

  adc_scan_scheduler_if bus ();

  adc_scan_scheduler #(
    .TIMEOUT_CYCLES(Tmo),
    .TMO_W         (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .chan_mask   (chan_mask),
    .period_tick (period_tick),
    .bus         (bus.master),
    .rd_chan     (rd_chan),
    .rd_data     (rd_data),
    .rd_fresh    (rd_fresh),
    .rd_ack      (rd_ack),
    .scan_done   (scan_done),
    .scan_overrun(scan_overrun),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #50 clk = ~clk;

  int checks    = 0;
  int passed    = 0;
  int n_done    = 0;
  int n_overrun = 0;
  int n_tmo     = 0;
  int n_rsp     = 0;

  logic [2:0]  exp_start_q [$];
  logic [12:0] exp_rsp_q   [$];  // {err, data}

  // ADC model: answers 12'h100+ch AdcLat cycles after each start.
  logic        adc_dead     = 1'b0;
  logic        adc_override = 1'b0;
  logic [11:0] adc_override_val = '0;
  logic        adc_pend     = 1'b0;
  int          adc_cnt      = 0;
  logic [2:0]  adc_ch       = '0;

  always @(negedge clk) begin
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    if (bus.adc_start === 1'b1) begin
      adc_pend = 1'b1;
      adc_cnt  = AdcLat;
      adc_ch   = bus.adc_channel;
    end else if (adc_pend) begin
      adc_cnt--;
      if (adc_cnt == 0) begin
        adc_pend = 1'b0;
        if (!adc_dead) begin
          bus.adc_valid = 1'b1;
          bus.adc_data  = adc_override ? adc_override_val : 12'h100 + 12'(adc_ch);
        end
      end
    end
  end

  logic [2:0]  mon_ch;
  logic [12:0] mon_rsp;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (scan_done)    n_done++;
      if (scan_overrun) n_overrun++;
      if (timeout_err)  n_tmo++;
      if (bus.adc_start) begin
        checks++;
        if (exp_start_q.size() == 0) begin
          $display("FAIL start_order: got start on ch %0d, required no start", bus.adc_channel);
        end else begin
          mon_ch = exp_start_q.pop_front();
          if (bus.adc_channel !== mon_ch)
            $display("FAIL start_order: got ch %0d, required ch %0d", bus.adc_channel, mon_ch);
          else passed++;
        end
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        checks++;
        if (exp_rsp_q.size() == 0) begin
          $display("FAIL response: got err=%b data=%h, required no response",
                   bus.rsp_err, bus.rsp_data);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          if ({bus.rsp_err, bus.rsp_data} !== mon_rsp)
            $display("FAIL response: got err=%b data=%h, required err=%b data=%h",
                     bus.rsp_err, bus.rsp_data, mon_rsp[12], mon_rsp[11:0]);
          else passed++;
        end
      end
    end
  end

  task automatic pulse_tick();
    @(posedge clk); #1 period_tick = 1'b1;
    @(posedge clk); #1 period_tick = 1'b0;
  endtask

  task automatic issue_req(input logic [2:0] ch);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_chan  = ch;
    for (int i = 0; i < 3000; i++) begin
      if (bus.req_ready) break;
      @(negedge clk);
    end
    @(posedge clk); #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; chan_mask = '0; period_tick = 1'b0;
    rd_chan = '0; rd_ack = 1'b0; bus.req_valid = 1'b0; bus.req_chan = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.adc_start, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.adc_channel,
         scan_done, scan_overrun, timeout_err, busy} !== 24'd0)
      $display("FAIL reset_outputs: got start=%b ready=%b rsp=%b/%b/%h ch=%0d done=%b ov=%b tmo=%b busy=%b, required all 0",
               bus.adc_start, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data,
               bus.adc_channel, scan_done, scan_overrun, timeout_err, busy);
    else passed++;
    for (int ch = 0; ch < 8; ch++) begin
      rd_chan = 3'(ch); #1;
      checks++;
      if ({rd_fresh, rd_data} !== 13'd0)
        $display("FAIL reset_bank ch%0d: got fresh=%b data=%h, required 0/000", ch, rd_fresh, rd_data);
      else passed++;
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_scan();
    int base;
    int chs[3] = '{0, 2, 7};
    base = n_done;
    exp_start_q.push_back(3'd0); exp_start_q.push_back(3'd2); exp_start_q.push_back(3'd7);
    scan_en = 1'b1; chan_mask = 8'b1000_0101;
    pulse_tick();
    for (int i = 0; i < 5000 && n_done == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (n_done - base !== 1) $display("FAIL scan_done_count: got %0d, required 1", n_done - base);
    else passed++;
    foreach (chs[k]) begin
      rd_chan = 3'(chs[k]); #1;
      checks++;
      if ({rd_fresh, rd_data} !== {1'b1, 12'h100 + 12'(chs[k])})
        $display("FAIL scan_result ch%0d: got fresh=%b data=%h, required 1/%h",
                 chs[k], rd_fresh, rd_data, 12'h100 + 12'(chs[k]));
      else passed++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL scan_idle_busy: got %b, required 0", busy);
    else passed++;
  endtask

  task automatic test_req_during_scan();
    int base;
    int base_rsp;
    base = n_done;
    base_rsp = n_rsp;
    exp_start_q.push_back(3'd0); exp_start_q.push_back(3'd5);
    exp_start_q.push_back(3'd2); exp_start_q.push_back(3'd7);
    exp_rsp_q.push_back({1'b0, 12'h105});
    pulse_tick();
    repeat (10) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL ready_while_converting: got %b, required 0", bus.req_ready);
    else passed++;
    issue_req(3'd5);
    for (int i = 0; i < 5000 && n_done == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ((n_done - base !== 1) || (n_rsp - base_rsp !== 1))
      $display("FAIL req_scan_counts: got done=%0d rsp=%0d, required 1/1", n_done - base, n_rsp - base_rsp);
    else passed++;
    rd_chan = 3'd5; #1;
    checks++;
    if ({rd_fresh, rd_data} !== {1'b1, 12'h105})
      $display("FAIL req_result ch5: got fresh=%b data=%h, required 1/105", rd_fresh, rd_data);
    else passed++;
  endtask

  task automatic test_overrun_fresh();
    int base;
    int base_ov;
    for (int ch = 0; ch < 8; ch++) begin
      @(posedge clk); #1 rd_chan = 3'(ch); rd_ack = 1'b1;
    end
    @(posedge clk); #1 rd_ack = 1'b0; rd_chan = 3'd2;
    @(negedge clk);
    checks++;
    if (rd_fresh !== 1'b0) $display("FAIL ack_clears ch2: got fresh=%b, required 0", rd_fresh);
    else passed++;
    base = n_done;
    base_ov = n_overrun;
    exp_start_q.push_back(3'd2);
    chan_mask = 8'b0000_0100;
    pulse_tick();
    repeat (20) @(posedge clk);
    pulse_tick();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (bus.adc_valid) break;
    end
    // The edge after the adc_valid capture is the STORE edge for ch 2.
    #1 rd_ack = 1'b1;
    @(posedge clk); #1 rd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_fresh !== 1'b1) $display("FAIL fresh_race ch2: got fresh=%b, required 1", rd_fresh);
    else passed++;
    for (int i = 0; i < 100 && n_done == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ((n_done - base !== 1) || (n_overrun - base_ov !== 1))
      $display("FAIL overrun_counts: got done=%0d overrun=%0d, required 1/1",
               n_done - base, n_overrun - base_ov);
    else passed++;
  endtask

  task automatic test_ignored_tick();
    scan_en = 1'b0; chan_mask = 8'hff;
    pulse_tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL tick_scan_disabled: got busy=%b, required 0", busy);
    else passed++;
    scan_en = 1'b1; chan_mask = 8'h00;
    pulse_tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL tick_empty_mask: got busy=%b, required 0", busy);
    else passed++;
  endtask

  task automatic test_timeout();
    int base_tmo;
    int k;
    base_tmo = n_tmo;
    adc_dead = 1'b1;
    exp_start_q.push_back(3'd3);
    exp_rsp_q.push_back({1'b1, 12'h000});
    issue_req(3'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.adc_start) break;
    end
    k = 0;
    for (int i = 1; i <= int'(Tmo) + 10; i++) begin
      @(negedge clk);
      k = i;
      if (timeout_err) break;
    end
    checks++;
    if (k !== int'(Tmo) + 1)
      $display("FAIL timeout_latency: got %0d cycles after WAIT entry, required %0d", k - 1, Tmo);
    else passed++;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err} !== 2'b11)
      $display("FAIL timeout_rsp: got valid=%b err=%b, required 1/1", bus.rsp_valid, bus.rsp_err);
    else passed++;
    repeat (AdcLat) @(negedge clk);
    rd_chan = 3'd3; #1;
    checks++;
    if ((rd_fresh !== 1'b0) || (n_tmo - base_tmo !== 1))
      $display("FAIL timeout_nostore: got fresh3=%b timeouts=%0d, required 0/1", rd_fresh, n_tmo - base_tmo);
    else passed++;
    adc_dead = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    exp_start_q.push_back(3'd4);
    issue_req(3'd4);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.adc_start, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.adc_channel,
         scan_done, scan_overrun, timeout_err, busy} !== 23'd0)
      $display("FAIL mid_wait_reset: got start=%b rsp=%b/%b/%h ch=%0d done=%b ov=%b tmo=%b busy=%b, required all 0",
               bus.adc_start, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.adc_channel,
               scan_done, scan_overrun, timeout_err, busy);
    else passed++;
    repeat (AdcLat + 10) @(negedge clk);
    for (int ch = 0; ch < 8; ch++) begin
      rd_chan = 3'(ch); #1;
      checks++;
      if ({rd_fresh, rd_data} !== 13'd0)
        $display("FAIL late_valid_ignored ch%0d: got fresh=%b data=%h, required 0/000",
                 ch, rd_fresh, rd_data);
      else passed++;
    end
    checks++;
    if ((busy !== 1'b0) || (bus.req_ready !== 1'b1))
      $display("FAIL post_reset_idle: got busy=%b ready=%b, required 0/1", busy, bus.req_ready);
    else passed++;
  endtask

`ifdef ADC_SCAN_AVG_EN
  task automatic test_avg();
    logic [11:0] want [2];
    logic [11:0] vals [2];
    int base;
    vals = '{12'h400, 12'h800};
    want = '{12'h400, 12'h500};
    adc_override = 1'b1;
    scan_en = 1'b1; chan_mask = 8'b0000_0010; rd_chan = 3'd1;
    for (int n = 0; n < 2; n++) begin
      adc_override_val = vals[n];
      base = n_done;
      exp_start_q.push_back(3'd1);
      pulse_tick();
      for (int i = 0; i < 1000 && n_done == base; i++) @(negedge clk);
      #1;
      checks++;
      if (rd_data !== want[n]) $display("FAIL avg_result step%0d: got %h, required %h", n, rd_data, want[n]);
      else passed++;
    end
    adc_override = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_req_during_scan();
    test_overrun_fresh();
    test_ignored_tick();
    test_timeout();
    test_reset_mid_wait();
`ifdef ADC_SCAN_AVG_EN
    test_avg();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if ((exp_start_q.size() != 0) || (exp_rsp_q.size() != 0))
      $display("FAIL scoreboard_drain: got %0d starts and %0d responses outstanding, required 0/0",
               exp_start_q.size(), exp_rsp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
